button_event_controller: RTL

BUTTON_EVENT_CONTROLLER -- requirements
Module: button_event_controller

---
 rtl/button_event_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/button_event_controller.sv
// Multi-channel button front end: synchroniser, debouncer, press/long/repeat event FSM,
// plus a single-step / continuous-mode step request generator.
module button_event_controller #(
   parameter int N_BTN           = 5,
   parameter int SYNC_STAGES     = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter int AUTO_PERIOD     = 33500000,
   parameter int STEP_IDX        = 0,
   parameter int MODE_IDX        = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] repeat_pulse,
   output logic             step_pulse,
   output logic             continuous_mode
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
   localparam int AW = $clog2(AUTO_PERIOD + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
   localparam logic          REP_EN    = (REPEAT_CYCLES > 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_HELD  = 2'd2
   } state_t;

   if ((STEP_IDX == MODE_IDX) || (STEP_IDX >= N_BTN) || (MODE_IDX >= N_BTN)) begin : g_bad_idx
      $error("button_event_controller: STEP_IDX and MODE_IDX must differ and be below N_BTN");
   end

   logic [N_BTN-1:0] level_v_s, rise_v_s, fall_v_s, long_v_s, rep_v_s;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_r;
      logic [DW-1:0]          deb_cnt_r;
      logic                   stable_r, prev_r;
      state_t                 state_r, state_next_s;
      logic [HW-1:0]          hold_cnt_r, hold_cnt_next_s;
      logic [RW-1:0]          rep_cnt_r, rep_cnt_next_s;
      logic                   long_s, rep_s;

      // synchroniser, debounce counter and stable-level history
      always_ff @(posedge clk) begin
         if (!reset) begin
            sync_r    <= '0;
            deb_cnt_r <= '0;
            stable_r  <= 1'b0;
            prev_r    <= 1'b0;
         end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in[i]};
            prev_r <= stable_r;
            if (sync_r[SYNC_STAGES-1] != stable_r) begin
               if (deb_cnt_r == DEB_LAST) begin
                  stable_r  <= ~stable_r;
                  deb_cnt_r <= '0;
               end else begin
                  deb_cnt_r <= deb_cnt_r + 1'b1;
               end
            end else begin
               deb_cnt_r <= '0;
            end
         end
      end

      assign level_v_s[i] = stable_r;
      assign rise_v_s[i]  = stable_r & ~prev_r;
      assign fall_v_s[i]  = ~stable_r & prev_r;
      assign long_v_s[i]  = long_s;
      assign rep_v_s[i]   = rep_s;

      // press/hold FSM state and counter registers
      always_ff @(posedge clk) begin
         if (!reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            rep_cnt_r  <= '0;
         end else begin
            state_r    <= state_next_s;
            hold_cnt_r <= hold_cnt_next_s;
            rep_cnt_r  <= rep_cnt_next_s;
         end
      end

      // press/hold FSM next state; a release in the threshold cycle suppresses the event
      always_comb begin
         state_next_s    = state_r;
         hold_cnt_next_s = hold_cnt_r;
         rep_cnt_next_s  = rep_cnt_r;
         long_s          = 1'b0;
         rep_s           = 1'b0;
         case (state_r)
            ST_IDLE: begin
               hold_cnt_next_s = '0;
               rep_cnt_next_s  = '0;
               if (rise_v_s[i]) begin
                  state_next_s = ST_PRESS;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end
            ST_PRESS: begin
               if (fall_v_s[i]) begin
                  state_next_s    = ST_IDLE;
                  hold_cnt_next_s = '0;
                  rep_cnt_next_s  = '0;
               end else if (hold_cnt_r == LONG_LAST) begin
                  state_next_s    = ST_HELD;
                  long_s          = 1'b1;
                  hold_cnt_next_s = '0;
                  rep_cnt_next_s  = '0;
               end else begin
                  hold_cnt_next_s = hold_cnt_r + 1'b1;
               end
            end
            ST_HELD: begin
               if (fall_v_s[i]) begin
                  state_next_s    = ST_IDLE;
                  hold_cnt_next_s = '0;
                  rep_cnt_next_s  = '0;
               end else if (REP_EN && (rep_cnt_r == REP_LAST)) begin
                  rep_s          = 1'b1;
                  rep_cnt_next_s = '0;
               end else if (REP_EN) begin
                  rep_cnt_next_s = rep_cnt_r + 1'b1;
               end else begin
                  rep_cnt_next_s = '0;
               end
            end
            default: begin
               state_next_s    = ST_IDLE;
               hold_cnt_next_s = '0;
               rep_cnt_next_s  = '0;
            end
         endcase
      end
   end

   logic [N_BTN-1:0] press_r, release_r, long_r, repeat_r;
   logic             step_r, mode_r;
   logic [AW-1:0]    auto_cnt_r, auto_cnt_next_s;
   logic             toggle_s, auto_fire_s, step_s;

   // step source selection; step-channel events use the mode value before any toggle
   always_comb begin
      toggle_s        = rise_v_s[MODE_IDX];
      auto_fire_s     = 1'b0;
      auto_cnt_next_s = '0;
      if (toggle_s || !mode_r) begin
         auto_cnt_next_s = '0;
      end else if (auto_cnt_r == AUTO_LAST) begin
         auto_fire_s     = 1'b1;
         auto_cnt_next_s = '0;
      end else begin
         auto_cnt_next_s = auto_cnt_r + 1'b1;
      end
      step_s = (~mode_r & (rise_v_s[STEP_IDX] | rep_v_s[STEP_IDX])) | auto_fire_s;
   end

   // registered event outputs, mode flag and auto-step counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         press_r    <= '0;
         release_r  <= '0;
         long_r     <= '0;
         repeat_r   <= '0;
         step_r     <= 1'b0;
         mode_r     <= 1'b0;
         auto_cnt_r <= '0;
      end else begin
         press_r    <= rise_v_s;
         release_r  <= fall_v_s;
         long_r     <= long_v_s;
         repeat_r   <= rep_v_s;
         step_r     <= step_s;
         mode_r     <= mode_r ^ toggle_s;
         auto_cnt_r <= auto_cnt_next_s;
      end
   end

   assign btn_level       = level_v_s;
   assign press_pulse     = press_r;
   assign release_pulse   = release_r;
   assign long_pulse      = long_r;
   assign repeat_pulse    = repeat_r;
   assign step_pulse      = step_r;
   assign continuous_mode = mode_r;

endmodule
